// File: rtl/reflet_gpu_pkg.sv
// ---------------------------------------------------------------------------
// reflet_gpu_pkg
// Definitions shared by the drawing engines:
//   - draw_state_e : IDLE / FILL / DRAIN sequencing of a drawing command
//   - DEF_H_SIZE / DEF_V_LINE : default screen geometry
//   - coord_width() : coordinate width for a given resolution ($clog2, min 1)
// ---------------------------------------------------------------------------
package reflet_gpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } draw_state_e;

    localparam int DEF_H_SIZE = 640;
    localparam int DEF_V_LINE = 480;

    // Width of a coordinate able to address n positions.
    function automatic int coord_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rect_sweep.sv
// ---------------------------------------------------------------------------
// rect_sweep
// Row-major cursor over an inclusive rectangle xmin..xmax / ymin..ymax.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   load                : capture bounds and place cursor at (ld_xmin, ld_ymin)
//   advance             : step cursor x+1, wrapping to xmin and y+1 at xmax
//   ld_xmin..ld_ymax    : bounds captured on load
//   x, y                : current cursor
//   last                : cursor sits on (xmax, ymax)
// The caller must not advance while last is high; the cursor therefore never
// steps past the bounds and no overflow handling is needed.
// ---------------------------------------------------------------------------
module rect_sweep
    import reflet_gpu_pkg::*;
#(
    parameter int HW = 10,
    parameter int VW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          advance,
    input  logic [HW-1:0] ld_xmin,
    input  logic [HW-1:0] ld_xmax,
    input  logic [VW-1:0] ld_ymin,
    input  logic [VW-1:0] ld_ymax,
    output logic [HW-1:0] x,
    output logic [VW-1:0] y,
    output logic          last
);

    localparam logic [HW-1:0] X_ONE = HW'(1);
    localparam logic [VW-1:0] Y_ONE = VW'(1);

    logic [HW-1:0] x_q, x_d;
    logic [VW-1:0] y_q, y_d;
    logic [HW-1:0] xmin_q, xmin_d;
    logic [HW-1:0] xmax_q, xmax_d;
    logic [VW-1:0] ymax_q, ymax_d;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        xmin_d = xmin_q;
        xmax_d = xmax_q;
        ymax_d = ymax_q;
        if (load) begin
            x_d    = ld_xmin;
            y_d    = ld_ymin;
            xmin_d = ld_xmin;
            xmax_d = ld_xmax;
            ymax_d = ld_ymax;
        end else if (advance) begin
            if (x_q == xmax_q) begin
                x_d = xmin_q;
                y_d = y_q + Y_ONE;
            end else begin
                x_d = x_q + X_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q    <= '0;
            y_q    <= '0;
            xmin_q <= '0;
            xmax_q <= '0;
            ymax_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            xmin_q <= xmin_d;
            xmax_q <= xmax_d;
            ymax_q <= ymax_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == xmax_q) && (y_q == ymax_q);

endmodule

// File: rtl/rect_filler.sv
// ---------------------------------------------------------------------------
// rect_filler
// Fills an axis-aligned rectangle with one colour, one pixel per clock, by
// driving the pixel memory write port. Coordinates lead write_en/color_write
// by one cycle to match the memory's registered address path.
// Ports:
//   clk, reset              : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready   : command handshake (ready == engine idle)
//   cmd_x0/x1, cmd_y0/y1    : corners in any order
//   cmd_color               : fill colour
//   busy                    : command in progress (FILL or DRAIN)
//   done                    : pulse with the final write_en
//   h/v_pixel_write         : write coordinates
//   write_en, color_write   : write strobe and data
// Build option RECT_FILLER_CLIP_EN: clamp corners to the screen on acceptance.
// ---------------------------------------------------------------------------
module rect_filler
    import reflet_gpu_pkg::*;
#(
    parameter  int h_size      = DEF_H_SIZE,
    parameter  int v_line      = DEF_V_LINE,
    parameter  int color_depth = 8,
    localparam int HW          = coord_width(h_size),
    localparam int VW          = coord_width(v_line)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [HW-1:0]          cmd_x0,
    input  logic [HW-1:0]          cmd_x1,
    input  logic [VW-1:0]          cmd_y0,
    input  logic [VW-1:0]          cmd_y1,
    input  logic [color_depth-1:0] cmd_color,
    output logic                   busy,
    output logic                   done,
    output logic [HW-1:0]          h_pixel_write,
    output logic [VW-1:0]          v_pixel_write,
    output logic                   write_en,
    output logic [color_depth-1:0] color_write
);

    draw_state_e state_q, state_d;

    logic [color_depth-1:0] color_q, color_d;
    logic [color_depth-1:0] color_write_q, color_write_d;
    logic                   write_en_q, write_en_d;

    logic          load, advance, last;
    logic [HW-1:0] cx0, cx1, xmin, xmax;
    logic [VW-1:0] cy0, cy1, ymin, ymax;

    // Corner conditioning: optional clamp, then order the corners.
`ifdef RECT_FILLER_CLIP_EN
    localparam logic [HW-1:0] X_LIM = HW'(h_size - 1);
    localparam logic [VW-1:0] Y_LIM = VW'(v_line - 1);
    assign cx0 = (cmd_x0 > X_LIM) ? X_LIM : cmd_x0;
    assign cx1 = (cmd_x1 > X_LIM) ? X_LIM : cmd_x1;
    assign cy0 = (cmd_y0 > Y_LIM) ? Y_LIM : cmd_y0;
    assign cy1 = (cmd_y1 > Y_LIM) ? Y_LIM : cmd_y1;
`else
    assign cx0 = cmd_x0;
    assign cx1 = cmd_x1;
    assign cy0 = cmd_y0;
    assign cy1 = cmd_y1;
`endif

    assign xmin = (cx0 < cx1) ? cx0 : cx1;
    assign xmax = (cx0 < cx1) ? cx1 : cx0;
    assign ymin = (cy0 < cy1) ? cy0 : cy1;
    assign ymax = (cy0 < cy1) ? cy1 : cy0;

    rect_sweep #(
        .HW (HW),
        .VW (VW)
    ) u_sweep (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .advance (advance),
        .ld_xmin (xmin),
        .ld_xmax (xmax),
        .ld_ymin (ymin),
        .ld_ymax (ymax),
        .x       (h_pixel_write),
        .y       (v_pixel_write),
        .last    (last)
    );

    // Next-state and control.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        color_d = color_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    load    = 1'b1;
                    color_d = cmd_color;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                // The final coordinate stays on the bus through DRAIN.
                if (last) begin
                    state_d = ST_DRAIN;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write strobe/data trail the presented coordinate by one cycle.
    always_comb begin
        write_en_d    = (state_q == ST_FILL);
        color_write_d = color_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            color_q       <= '0;
            color_write_q <= '0;
            write_en_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            color_q       <= color_d;
            color_write_q <= color_write_d;
            write_en_q    <= write_en_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    // DRAIN is exactly the cycle carrying the final write.
    assign done        = (state_q == ST_DRAIN);
    assign write_en    = write_en_q;
    assign color_write = color_write_q;

endmodule
